// File: rtl/seg_scan_mux_pwm.sv
// Multiplexed N-digit 7-segment scan driver with per-slot dead time, per-digit
// blanking, PWM brightness, selectable polarity and frame-synchronous input capture.
module seg_scan_mux_pwm #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int REFRESH_RATE_HZ = 1000,
  parameter int NUM_DIGITS      = 4,
  parameter int SEG_W           = 8,
  parameter int DEAD_CYCLES     = 64,
  parameter int BRIGHT_W        = 4,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int SEL_ACTIVE_LOW  = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             enable,
  input  logic [NUM_DIGITS*SEG_W-1:0]                      seg_in,
  input  logic [NUM_DIGITS-1:0]                            blank,
  input  logic [BRIGHT_W-1:0]                              brightness,
  output logic [SEG_W-1:0]                                 seg_out,
  output logic [NUM_DIGITS-1:0]                            sel_out,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                             frame_tick
);

  localparam int SLOT_CYCLES = CLK_FREQ / (REFRESH_RATE_HZ * NUM_DIGITS);
  localparam int ACTIVE_LEN  = SLOT_CYCLES - DEAD_CYCLES;
  localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LEN_W       = (ACTIVE_LEN > 0) ? $clog2(ACTIVE_LEN + 1) : 1;
  localparam int PROD_W      = LEN_W + BRIGHT_W;
  localparam int CMP_W       = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

  localparam logic [CNT_W-1:0]      SLOT_LAST    = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST     = DIG_W'(NUM_DIGITS - 1);
  localparam logic [LEN_W-1:0]      ACTIVE_LEN_L = LEN_W'(ACTIVE_LEN);
  localparam logic [CMP_W-1:0]      DEAD_EXT     = CMP_W'(DEAD_CYCLES);
  localparam logic [SEG_W-1:0]      SEG_IDLE     = {SEG_W{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE     = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

  generate
    if (ACTIVE_LEN < 1) begin : g_bad_cfg
      $error("seg_scan_mux_pwm: DEAD_CYCLES leaves no active time in a slot");
    end
  endgenerate

  logic [CNT_W-1:0]            slot_cnt, slot_nxt;
  logic [DIG_W-1:0]            dig_nxt;
  logic                        prime;
  logic                        frame_end;
  logic                        capture;
  logic [NUM_DIGITS*SEG_W-1:0] snap_seg, snap_seg_nxt;
  logic [NUM_DIGITS-1:0]       snap_blank, snap_blank_nxt;
  logic [LEN_W-1:0]            on_len, on_len_nxt, on_len_calc;
  logic [PROD_W-1:0]           product;
  logic [CMP_W-1:0]            slot_ext;
  logic [SEG_W-1:0]            seg_d;
  logic [NUM_DIGITS-1:0]       sel_d;

  // Capture happens on the last cycle of a frame, or on the first enabled cycle
  // after reset / disable so the display never shows stale data.
  assign frame_end  = (slot_cnt == SLOT_LAST) && (digit_idx == DIG_LAST);
  assign capture    = enable && !rst && (prime || frame_end);
  assign frame_tick = capture;

  // Full product kept before the shift so no brightness step is lost.
  assign product     = PROD_W'(ACTIVE_LEN_L) * PROD_W'(brightness);
  assign on_len_calc = (&brightness) ? ACTIVE_LEN_L : LEN_W'(product >> BRIGHT_W);

  assign snap_seg_nxt   = capture ? seg_in      : snap_seg;
  assign snap_blank_nxt = capture ? blank       : snap_blank;
  assign on_len_nxt     = capture ? on_len_calc : on_len;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    slot_nxt = '0;
    dig_nxt  = '0;
    if (enable) begin
      if (slot_cnt == SLOT_LAST) begin
        dig_nxt = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        slot_nxt = slot_cnt + 1'b1;
        dig_nxt  = digit_idx;
      end
    end
  end

  // Drive values are decoded from next-state counters so the registered pins
  // line up with the slot_cnt/digit_idx visible in the same cycle.
  always_comb begin
    seg_d    = SEG_IDLE;
    sel_d    = SEL_IDLE;
    slot_ext = CMP_W'(slot_nxt);
    if (enable && !snap_blank_nxt[dig_nxt]) begin
      seg_d = snap_seg_nxt[dig_nxt*SEG_W +: SEG_W] ^ SEG_IDLE;
      if (slot_ext >= DEAD_EXT && slot_ext < DEAD_EXT + CMP_W'(on_len_nxt)) begin
        sel_d = SEL_IDLE ^ (NUM_DIGITS'(1) << dig_nxt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      prime      <= 1'b1;
      // NOTE: the snapshot is a few flops, not a memory array, so it is reset
      // to an all-blank, zero-brightness frame.
      snap_seg   <= '0;
      snap_blank <= '1;
      on_len     <= '0;
      seg_out    <= SEG_IDLE;
      sel_out    <= SEL_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      slot_cnt   <= slot_nxt;
      digit_idx  <= dig_nxt;
      prime      <= !enable;
      snap_seg   <= snap_seg_nxt;
      snap_blank <= snap_blank_nxt;
      on_len     <= on_len_nxt;
      seg_out    <= seg_d;
      sel_out    <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux_pwm.sv
// Randomised self-checking bench for seg_scan_mux_pwm against a frame-level
// model: position in the frame, captured snapshot and brightness arithmetic.
module tb_seg_scan_mux_pwm;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 8;
  localparam int SLOT       = 16;
  localparam int DEAD       = 2;
  localparam int ACTIVE     = 14;
  localparam int FRAME      = SLOT * NUM_DIGITS;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] seg_in;
  logic [3:0]  blank;
  logic [3:0]  brightness;
  logic [7:0]  seg_out;
  logic [3:0]  sel_out;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  seg_scan_mux_pwm #(
    .CLK_FREQ(64_000), .REFRESH_RATE_HZ(1000), .NUM_DIGITS(NUM_DIGITS),
    .SEG_W(SEG_W), .DEAD_CYCLES(DEAD), .BRIGHT_W(4),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .seg_in(seg_in), .blank(blank),
    .brightness(brightness), .seg_out(seg_out), .sel_out(sel_out),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: k counts consecutive enabled edges since the last disable/reset.
  int         k = 0;
  logic [7:0] m_seg [NUM_DIGITS];
  logic [3:0] m_blank;
  int         m_bright;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int pos, d, c, on;
    logic [7:0] e_seg;
    logic [3:0] e_sel;
    logic [1:0] e_dig;
    e_seg = 8'hFF;
    e_sel = 4'hF;
    e_dig = 2'd0;
    if (k > 0 && !rst) begin
      pos   = k % FRAME;
      d     = pos / SLOT;
      c     = pos % SLOT;
      e_dig = 2'(d);
      if (!m_blank[d]) begin
        e_seg = ~m_seg[d];
        on    = (m_bright == 15) ? ACTIVE : (ACTIVE * m_bright) / 16;
        if (c >= DEAD && c < DEAD + on) e_sel = ~(4'b0001 << d);
      end
    end
    check("seg_out", seg_out, e_seg);
    check("sel_out", sel_out, e_sel);
    check("digit_idx", digit_idx, e_dig);
    check("sel_onehot", ($countones(~sel_out) <= 1), 1);
  endtask

  task automatic cycle();
    #1;
    check("frame_tick", frame_tick, enable && !rst && (k == 0 || k % FRAME == FRAME - 1));
    @(posedge clk);
    if (rst || !enable) begin
      k = 0;
    end else begin
      if (k == 0 || k % FRAME == FRAME - 1) begin
        for (int i = 0; i < NUM_DIGITS; i++) m_seg[i] = seg_in[i*SEG_W +: SEG_W];
        m_blank  = blank;
        m_bright = int'(brightness);
      end
      k++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (!(k > 0 && k % FRAME == target) && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    check("sync_digit", digit_idx, target / SLOT);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    seg_in     = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    blank      = 4'b0000;
    brightness = 4'd15;
    m_blank    = 4'hF;
    m_bright   = 0;
    for (int i = 0; i < NUM_DIGITS; i++) m_seg[i] = 8'h00;

    #2;
    check("rst_seg_out", seg_out, 8'hFF);
    check("rst_sel_out", sel_out, 4'hF);
    check("rst_frame_tick", frame_tick, 0);
    run(3);

    // Full brightness, reference patterns, two complete frames.
    rst    = 1'b0;
    enable = 1'b1;
    run(2 * FRAME);

    // Half brightness then off; takes effect from the next frame boundary.
    brightness = 4'd8;
    run(2 * FRAME);
    brightness = 4'd0;
    run(2 * FRAME);

    brightness = 4'd15;
    blank      = 4'b0100;
    run(2 * FRAME);
    blank = 4'b0000;
    run(FRAME);

    // Mid-frame edit of digit 0 at (digit 1, cnt 5).
    run_until(SLOT + 5);
    seg_in[7:0] = 8'h7F;
    run(2 * FRAME);

    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(FRAME + 10);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) begin
        seg_in     = $urandom;
        brightness = 4'($urandom_range(15));
      end
      if ($urandom_range(39) == 0) blank = 4'($urandom_range(15));
      if ($urandom_range(199) == 0) enable = ~enable;
      cycle();
    end

    // Asynchronous reset in the middle of digit 2's slot.
    enable     = 1'b1;
    blank      = 4'b0000;
    brightness = 4'd15;
    run(FRAME);
    run_until(2 * SLOT + 9);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", sel_out, 4'hF);
    check("async_rst_seg", seg_out, 8'hFF);
    check("async_rst_tick", frame_tick, 0);
    run(3);
    rst = 1'b0;
    run(3 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
